hash_req_arbiter: RTL and testbench
===================================

// Module: hash_req_arbiter
// PURPOSE
//  Shares the single count-min hash pipeline between NUM_REQ address requesters (one per memory channel).
//  Round-robin grants one address per cycle into the hash pipeline and carries the winner's id alongside it.
//  Re-tags hashed results with that id when they emerge.
//  Issue is credit-gated so the downstream bank-update buffer can never overflow.
// PARAMETERS
//  NUM_REQ       2    number of requesters (>=2)
//  ADDR_SIZE     22   request address width
//  HASH_LATENCY  6    cycles from hash_in_valid to hash_out_valid in the hash pipeline
//  CREDITS       8    downstream buffer depth = initial credit count
//  ID_SIZE       $clog2(NUM_REQ)  requester id width
//  CRED_SIZE     $clog2(CREDITS+1) credit counter width
// PORTS
//  clk             in   1                   clock
//  rst_n           in   1                   async active-low reset
//  req_valid       in   [NUM_REQ]           requester i has an address
//  req_addr        in   [NUM_REQ][ADDR_SIZE] requester i address
//  req_ready       out  [NUM_REQ]           grant; transfer when valid&ready
//  hash_in_valid   out  1                   issue to hash pipeline (registered)
//  hash_in_addr    out  ADDR_SIZE           issued address (registered)
//  hash_out_valid  in   1                   hash pipeline result valid
//  hash_out_addr   in   ADDR_SIZE           hash pipeline result address
//  tag_valid       out  1                   tagged result valid (= hash_out_valid)
//  tag_addr        out  ADDR_SIZE           = hash_out_addr
//  tag_id          out  ID_SIZE             requester id of this result
//  credit_return   in   1                   downstream freed one entry (1-cycle pulse)
//  credits_avail   out  CRED_SIZE           current credit count
//  err_sticky      out  1                   tag misalignment or credit overflow seen
// BEHAVIOUR
//  - clk is the single clock; rst_n is asynchronous, active-low.
//  - Reset values: hash_in_valid=0, hash_in_addr=0, credits_avail=CREDITS, rr pointer=0, id pipe valid bits=0, err_sticky=0.
//  - Grant (combinational): only when credits_avail!=0. Scan requesters starting at rr pointer; the first with req_valid wins.
//    - req_ready is one-hot or zero.
//    - req_ready never depends on credit_return in the same cycle.
//  - On transfer from requester w: next cycle hash_in_valid=1 and hash_in_addr=req_addr[w].
//    - rr pointer <= (w+1) mod NUM_REQ. The pointer is unchanged when there is no transfer.
//  - Id pipe: HASH_LATENCY-deep shift of {valid,id}, loaded alongside hash_in_valid.
//    - Its tail aligns with hash_out_valid exactly HASH_LATENCY cycles after hash_in_valid.
//  - tag_valid/tag_addr are combinational pass-through. tag_id = id-pipe tail id.
//    - If hash_out_valid != tail valid, err_sticky<=1. Tags keep flowing.
//  - Credits, per cycle (issue = transfer this cycle):
//    - issue only: credits-1.
//    - return only: credits+1.
//    - both: unchanged.
//    - return when credits==CREDITS with no issue: ignored, err_sticky<=1.
//    - credits==0 is the stall point: all req_ready=0.
//  - Throughput: 1 address/cycle while credits>0. Latency req transfer -> tag_valid = HASH_LATENCY+1.
//  - Reset mid-operation: in-flight ids are discarded and credits are restored to CREDITS.
//    The hash pipeline is reset by the same rst_n.
//  - err_sticky clears only on reset.
// CONFIGURATION
//  - HASH_ARB_PERF_CNT_EN defined: adds outputs perf_grant_cnt[NUM_REQ][32] and perf_stall_cnt[32].
//    - perf_grant_cnt counts transfers per requester.
//    - perf_stall_cnt counts cycles with any req_valid and credits==0.
//    - Both counters saturate at 2^32-1 and reset to 0.
//  - Not defined: those ports and counters do not exist.
// STRUCTURE
//  - hash_arb_pkg: ID_SIZE/HASH_LATENCY defaults, typedef req_id_t, typedef struct tag_pipe_t {logic v; req_id_t id;}.
//  - Sub-module hash_rr_grant: combinational round-robin pick (valid vector, pointer -> one-hot grant, winner index).
//  - Credit counter, id pipe, issue registers and perf counters stay in hash_arb_pkg's user, hash_req_arbiter.
// TESTING
//  - Single request:
//    - Stimulus: req0 addr=0x12345 alone.
//    - Response: req_ready[0] same cycle; hash_in_valid next cycle with addr 0x12345;
//      tag_id=0 HASH_LATENCY cycles later; credits 8->7.
//  - Fairness:
//    - Stimulus: both requesters valid continuously, credit_return every cycle.
//    - Response: grants alternate 0,1,0,1...; 100 transfers -> 50/50; tag_id order matches grant order.
//  - Credit stall:
//    - Stimulus: no credit_return, both valid.
//    - Response: exactly 8 transfers, then req_ready=0 and credits_avail=0.
//      One credit_return pulse -> exactly one more transfer.
//  - Simultaneous issue and return:
//    - Stimulus: credits=3, transfer and credit_return in the same cycle.
//    - Response: credits stay 3.
//    - Stimulus: return at credits=8 with no issue.
//    - Response: stays 8, err_sticky=1.
//  - Misalignment:
//    - Stimulus: inject hash_out_valid with id pipe tail empty.
//    - Response: err_sticky=1, tag_valid=1 still passes through.
//  - Reset mid-flight:
//    - Stimulus: assert rst_n low with 4 in flight.
//    - Response: outputs go to reset values immediately (async); after release credits_avail=8 and no stale tag_valid.

Source files
------------

// File: rtl/hash_arb_pkg.sv
// Shared types and defaults for the count-min hash request arbiter.
// Holds the default requester count and hash pipeline depth, the requester id
// type carried through the id pipe, and the round-robin pointer helper.
package hash_arb_pkg;

   localparam int NUM_REQ_DEF      = 2;
   localparam int ID_SIZE_DEF      = $clog2(NUM_REQ_DEF);
   localparam int HASH_LATENCY_DEF = 6;

   // Id storage is sized for up to 256 requesters; narrower builds use the low bits.
   localparam int ID_MAX_SIZE = 8;

   typedef logic [ID_MAX_SIZE-1:0] req_id_t;

   // One entry of the id pipe that shadows the hash pipeline.
   typedef struct packed {
      logic    v;
      req_id_t id;
   } tag_pipe_t;

   // Next round-robin start position after requester idx wins, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/hash_rr_grant.sv
// Combinational round-robin picker.
// Scans the valid vector starting at ptr and grants the first requester found.
// The grant is one-hot or zero; win_idx is meaningful only when any_grant is set.
module hash_rr_grant #(
   parameter int NUM_REQ = 2,
   parameter int ID_SIZE = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_SIZE-1:0] ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_SIZE-1:0] win_idx,
   output logic               any_grant
);

   int                 idx;
   logic [ID_SIZE-1:0] idx_w;

   // Walk the requesters in priority order ptr, ptr+1, ... and stop at the first valid one.
   always_comb begin
      grant     = '0;
      win_idx   = '0;
      any_grant = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx   = (int'(ptr) + k) % NUM_REQ;
         idx_w = ID_SIZE'(idx);
         if (!any_grant && valid[idx_w]) begin
            grant[idx_w] = 1'b1;
            win_idx      = idx_w;
            any_grant    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one count-min hash pipeline between NUM_REQ address requesters.
// Round-robin issues one address per cycle, shadows the hash pipeline with an
// id pipe so results come back tagged with their requester, and gates issue on
// credits so the downstream bank-update buffer never overflows.
// Optional build macro HASH_ARB_PERF_CNT_EN adds saturating per-requester grant
// counters and a credit-stall cycle counter.
module hash_req_arbiter
   import hash_arb_pkg::*;
#(
   parameter int NUM_REQ      = hash_arb_pkg::NUM_REQ_DEF,
   parameter int ADDR_SIZE    = 22,
   parameter int HASH_LATENCY = hash_arb_pkg::HASH_LATENCY_DEF,
   parameter int CREDITS      = 8,
   parameter int ID_SIZE      = $clog2(NUM_REQ),
   parameter int CRED_SIZE    = $clog2(CREDITS + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]  req_addr,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               hash_in_valid,
   output logic [ADDR_SIZE-1:0]               hash_in_addr,
   input  logic                               hash_out_valid,
   input  logic [ADDR_SIZE-1:0]               hash_out_addr,
   output logic                               tag_valid,
   output logic [ADDR_SIZE-1:0]               tag_addr,
   output logic [ID_SIZE-1:0]                 tag_id,
   input  logic                               credit_return,
   output logic [CRED_SIZE-1:0]               credits_avail,
   output logic                               err_sticky
`ifdef HASH_ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ-1:0][31:0]           perf_grant_cnt,
   output logic [31:0]                        perf_stall_cnt
`endif
);

   localparam logic [CRED_SIZE-1:0] CRED_FULL = CRED_SIZE'(CREDITS);
   localparam logic [CRED_SIZE-1:0] CRED_ONE  = CRED_SIZE'(1);

   genvar gi;

   logic                              credit_ok;
   logic [NUM_REQ-1:0]                elig;
   logic [NUM_REQ-1:0]                grant;
   logic [ID_SIZE-1:0]                win_idx;
   logic                              issue;

   logic [CRED_SIZE-1:0]              credits_reg;
   logic [CRED_SIZE-1:0]              credits_next;
   logic                              cred_overflow;

   logic [ID_SIZE-1:0]                rr_ptr_reg;
   logic                              hash_in_valid_reg;
   logic [ADDR_SIZE-1:0]              hash_in_addr_reg;
   req_id_t                           hash_in_id_reg;

   tag_pipe_t [HASH_LATENCY-1:0]      id_pipe_reg;
   tag_pipe_t                         pipe_tail;
   logic                              misalign;
   logic                              err_sticky_reg;

   // ------------------------------------------------------------------
   // Grant: only requesters with an address, and only while credit remains.
   // The grant never looks at credit_return, so a same-cycle return cannot
   // open a grant combinationally.
   // ------------------------------------------------------------------
   assign credit_ok = (credits_reg != '0);

   for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign elig[gi] = req_valid[gi] & credit_ok;
   end

   hash_rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_SIZE (ID_SIZE)
   ) u_rr_grant (
      .valid     (elig),
      .ptr       (rr_ptr_reg),
      .grant     (grant),
      .win_idx   (win_idx),
      .any_grant (issue)
   );

   assign req_ready = grant;

   // Issue register: capture the winning address and id, advance the rr pointer past the winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hash_in_valid_reg <= 1'b0;
         hash_in_addr_reg  <= '0;
         hash_in_id_reg    <= '0;
         rr_ptr_reg        <= '0;
      end else begin
         hash_in_valid_reg <= issue;
         if (issue) begin
            hash_in_addr_reg <= req_addr[win_idx];
            hash_in_id_reg   <= req_id_t'(win_idx);
            rr_ptr_reg       <= ID_SIZE'(rr_next(int'(win_idx), NUM_REQ));
         end
      end
   end

   assign hash_in_valid = hash_in_valid_reg;
   assign hash_in_addr  = hash_in_addr_reg;

   // ------------------------------------------------------------------
   // Credits: issue consumes one, return frees one, both together cancel.
   // A return with the counter already full is dropped and flagged.
   // ------------------------------------------------------------------
   // Next credit count and overflow detect.
   always_comb begin
      credits_next  = credits_reg;
      cred_overflow = 1'b0;
      case ({issue, credit_return})
         2'b10: credits_next = credits_reg - CRED_ONE;
         2'b01: begin
            if (credits_reg == CRED_FULL) begin
               cred_overflow = 1'b1;
            end else begin
               credits_next = credits_reg + CRED_ONE;
            end
         end
         default: credits_next = credits_reg;
      endcase
   end

   // Credit counter register, restored to full on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_reg <= CRED_FULL;
      end else begin
         credits_reg <= credits_next;
      end
   end

   assign credits_avail = credits_reg;

   // ------------------------------------------------------------------
   // Id pipe: fed from the issue register, so an entry reaches the tail in the
   // same cycle the hash pipeline presents that address's result.
   // ------------------------------------------------------------------
   // Shift {valid,id} one stage per cycle behind hash_in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_pipe_reg <= '0;
      end else begin
         for (int i = HASH_LATENCY - 1; i > 0; i--) begin
            id_pipe_reg[i] <= id_pipe_reg[i-1];
         end
         id_pipe_reg[0] <= '{v: hash_in_valid_reg, id: hash_in_id_reg};
      end
   end

   assign pipe_tail = id_pipe_reg[HASH_LATENCY-1];
   assign misalign  = (hash_out_valid != pipe_tail.v);

   // Results pass straight through; only the id comes from the pipe tail.
   assign tag_valid = hash_out_valid;
   assign tag_addr  = hash_out_addr;
   assign tag_id    = ID_SIZE'(pipe_tail.id);

   // Sticky error: misaligned result or credit overflow, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky_reg <= 1'b0;
      end else if (misalign || cred_overflow) begin
         err_sticky_reg <= 1'b1;
      end
   end

   assign err_sticky = err_sticky_reg;

`ifdef HASH_ARB_PERF_CNT_EN
   // ------------------------------------------------------------------
   // Performance counters, saturating at all-ones.
   // ------------------------------------------------------------------
   logic        stall_cycle;
   logic [31:0] stall_cnt_reg;

   assign stall_cycle = (|req_valid) && !credit_ok;

   for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf_grant
      logic [31:0] cnt_reg;

      // Count transfers from requester gi.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_reg <= '0;
         end else if (grant[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 32'd1;
         end
      end

      assign perf_grant_cnt[gi] = cnt_reg;
   end

   // Count cycles where someone is waiting but no credit is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (stall_cycle && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Testbench for hash_req_arbiter: directed vectors with hand-computed grants and
// credit counts; expected tags are queued at issue and checked by an independent
// monitor when tag_valid appears. Includes a behavioural hash pipeline.
module tb_hash_req_arbiter;

   localparam int NUM_REQ      = 2;
   localparam int ADDR_SIZE    = 22;
   localparam int HASH_LATENCY = 6;
   localparam int CREDITS      = 8;
   localparam int ID_SIZE      = 1;
   localparam int CRED_SIZE    = 4;

   logic                              clk = 1'b0;
   logic                              rst_n = 1'b1;
   logic [NUM_REQ-1:0]                req_valid;
   logic [NUM_REQ-1:0][ADDR_SIZE-1:0] req_addr;
   logic [NUM_REQ-1:0]                req_ready;
   logic                              hash_in_valid;
   logic [ADDR_SIZE-1:0]              hash_in_addr;
   logic                              hash_out_valid;
   logic [ADDR_SIZE-1:0]              hash_out_addr;
   logic                              tag_valid;
   logic [ADDR_SIZE-1:0]              tag_addr;
   logic [ID_SIZE-1:0]                tag_id;
   logic                              credit_return;
   logic [CRED_SIZE-1:0]              credits_avail;
   logic                              err_sticky;
`ifdef HASH_ARB_PERF_CNT_EN
   logic [NUM_REQ-1:0][31:0]          perf_grant_cnt;
   logic [31:0]                       perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   hash_req_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .ADDR_SIZE    (ADDR_SIZE),
      .HASH_LATENCY (HASH_LATENCY),
      .CREDITS      (CREDITS),
      .ID_SIZE      (ID_SIZE),
      .CRED_SIZE    (CRED_SIZE)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .hash_in_valid  (hash_in_valid),
      .hash_in_addr   (hash_in_addr),
      .hash_out_valid (hash_out_valid),
      .hash_out_addr  (hash_out_addr),
      .tag_valid      (tag_valid),
      .tag_addr       (tag_addr),
      .tag_id         (tag_id),
      .credit_return  (credit_return),
      .credits_avail  (credits_avail),
      .err_sticky     (err_sticky)
`ifdef HASH_ARB_PERF_CNT_EN
      ,
      .perf_grant_cnt (perf_grant_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Behavioural hash pipeline: fixed HASH_LATENCY delay, reset by the same rst_n.
   logic [HASH_LATENCY-1:0] hp_v;
   logic [ADDR_SIZE-1:0]    hp_a [HASH_LATENCY];
   logic                    inject = 1'b0;
   logic [ADDR_SIZE-1:0]    inj_addr = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hp_v <= '0;
         for (int k = 0; k < HASH_LATENCY; k++) hp_a[k] <= '0;
      end else begin
         hp_v    <= {hp_v[HASH_LATENCY-2:0], hash_in_valid};
         hp_a[0] <= hash_in_addr;
         for (int k = 1; k < HASH_LATENCY; k++) hp_a[k] <= hp_a[k-1];
      end
   end

   assign hash_out_valid = hp_v[HASH_LATENCY-1] | inject;
   assign hash_out_addr  = inject ? inj_addr : hp_a[HASH_LATENCY-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      logic [ID_SIZE-1:0]   id;
      logic [ADDR_SIZE-1:0] addr;
      int                   due;
   } exp_t;

   exp_t                 sb_q[$];
   logic [ADDR_SIZE-1:0] next_addr [NUM_REQ];
   int                   gcnt [NUM_REQ];

   // Monitor: compares each tagged result against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!inject) begin
            if (tag_valid) begin
               if (sb_q.size() == 0) begin
                  chk("tag_unexpected", 32'(tag_valid), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("tag_id", 32'(tag_id), 32'(e.id));
                  chk("tag_addr", 32'(tag_addr), 32'(e.addr));
                  chk("tag_cycle", cyc, e.due);
                  $display("tag    id=%0d addr=0x%06h cycle=%0d", tag_id, tag_addr, cyc);
               end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
               e = sb_q.pop_front();
               chk("tag_missing", 32'(tag_valid), 32'd1);
            end
         end
      end
   end

   // One stimulus cycle with hand-computed grant and current credit count.
   task automatic step(input logic [1:0] v, input logic ret, input logic [1:0] exp_rdy,
                       input int exp_cred, input string nm);
      exp_t e;
      @(negedge clk);
      req_valid     = v;
      credit_return = ret;
      req_addr[0]   = next_addr[0];
      req_addr[1]   = next_addr[1];
      #1;
      chk({nm, "_ready"}, 32'(req_ready), 32'(exp_rdy));
      chk({nm, "_credits"}, 32'(credits_avail), exp_cred);
      for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) gcnt[i]++;
      if (exp_rdy != 2'b00) begin
         e.id   = exp_rdy[1] ? 1'b1 : 1'b0;
         e.addr = exp_rdy[1] ? next_addr[1] : next_addr[0];
         e.due  = cyc + HASH_LATENCY + 1;
         sb_q.push_back(e);
         $display("issue  id=%0d addr=0x%06h cycle=%0d", e.id, e.addr, cyc);
         next_addr[e.id] = next_addr[e.id] + 22'h111;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid     = '0;
      req_addr      = '0;
      credit_return = 1'b0;
      next_addr[0]  = 22'h12345;
      next_addr[1]  = 22'h20000;
      gcnt[0] = 0;
      gcnt[1] = 0;

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      chk("rst_hash_in_valid", 32'(hash_in_valid), 32'd0);
      chk("rst_hash_in_addr", 32'(hash_in_addr), 32'd0);
      chk("rst_credits", 32'(credits_avail), 32'd8);
      chk("rst_err", 32'(err_sticky), 32'd0);
      chk("rst_tag_valid", 32'(tag_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request from requester 0
      step(2'b01, 1'b0, 2'b01, 8, "single");
      step(2'b00, 1'b0, 2'b00, 7, "single_idle");
      chk("single_hin_valid", 32'(hash_in_valid), 32'd1);
      chk("single_hin_addr", 32'(hash_in_addr), 32'h12345);
      step(2'b00, 1'b0, 2'b00, 7, "single_idle2");
      chk("single_hin_clear", 32'(hash_in_valid), 32'd0);

      // Fairness: pointer sits at 1 after the single grant, so 1,0,1,0...
      gcnt[0] = 0;
      gcnt[1] = 0;
      for (int i = 0; i < 100; i++)
         step(2'b11, 1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 7, "fair");
      chk("fair_cnt0", 32'(gcnt[0]), 32'd50);
      chk("fair_cnt1", 32'(gcnt[1]), 32'd50);

      // Credit stall: refill to 8, then exactly 8 transfers
      step(2'b00, 1'b1, 2'b00, 7, "stall_refill");
      gcnt[0] = 0;
      gcnt[1] = 0;
      for (int i = 0; i < 8; i++)
         step(2'b11, 1'b0, (i % 2 == 0) ? 2'b10 : 2'b01, 8 - i, "stall_fill");
      step(2'b11, 1'b0, 2'b00, 0, "stall_hold");
      step(2'b11, 1'b0, 2'b00, 0, "stall_hold");
      step(2'b11, 1'b1, 2'b00, 0, "stall_ret");
      step(2'b11, 1'b0, 2'b10, 1, "stall_one");
      step(2'b11, 1'b0, 2'b00, 0, "stall_after");
      chk("stall_transfers", 32'(gcnt[0] + gcnt[1]), 32'd9);

      // Simultaneous issue and return at credits=3
      step(2'b00, 1'b1, 2'b00, 0, "sim_ret");
      step(2'b00, 1'b1, 2'b00, 1, "sim_ret");
      step(2'b00, 1'b1, 2'b00, 2, "sim_ret");
      step(2'b01, 1'b1, 2'b01, 3, "sim_both");
      step(2'b00, 1'b0, 2'b00, 3, "sim_hold");
      for (int i = 0; i < 5; i++) step(2'b00, 1'b1, 2'b00, 3 + i, "sim_refill");

      // Return while full
      step(2'b00, 1'b0, 2'b00, 8, "full_pre");
      chk("full_err_pre", 32'(err_sticky), 32'd0);
      step(2'b00, 1'b1, 2'b00, 8, "full_ret");
      step(2'b00, 1'b0, 2'b00, 8, "full_post");
      chk("full_err_post", 32'(err_sticky), 32'd1);

      // Reset with 4 in flight
      for (int i = 0; i < 10; i++) step(2'b00, 1'b0, 2'b00, 8, "drain");
      step(2'b11, 1'b0, 2'b10, 8, "mid");
      step(2'b11, 1'b0, 2'b01, 7, "mid");
      step(2'b11, 1'b0, 2'b10, 6, "mid");
      step(2'b11, 1'b0, 2'b01, 5, "mid");
      @(negedge clk);
      req_valid = 2'b00;
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_hin_valid", 32'(hash_in_valid), 32'd0);
      chk("mid_rst_credits", 32'(credits_avail), 32'd8);
      chk("mid_rst_err", 32'(err_sticky), 32'd0);
      chk("mid_rst_tag_valid", 32'(tag_valid), 32'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < HASH_LATENCY + 3; i++) step(2'b00, 1'b0, 2'b00, 8, "post_rst");
      chk("post_rst_err", 32'(err_sticky), 32'd0);

      // Misalignment: result with an empty id-pipe tail
      @(negedge clk);
      inject   = 1'b1;
      inj_addr = 22'h3ABCD;
      #1;
      chk("mis_tag_valid", 32'(tag_valid), 32'd1);
      chk("mis_tag_addr", 32'(tag_addr), 32'h3ABCD);
      chk("mis_err_pre", 32'(err_sticky), 32'd0);
      @(negedge clk);
      inject = 1'b0;
      #1;
      chk("mis_err_post", 32'(err_sticky), 32'd1);
      chk("mis_tag_clear", 32'(tag_valid), 32'd0);

      repeat (HASH_LATENCY + 3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
